// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests under a credit limit, buffers
// returned words with their PCs in a small FIFO, and flushes on core redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    output logic        fetch_err
);
    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;
    localparam logic [0:0]     ST_BOOT = 1'b0;
    localparam logic [0:0]     ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic          fetch_err_q, fetch_err_d;
    logic [31:0]   fifo_pc_q [DEPTH];
    logic [31:0]   fifo_pc_d [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];

    logic [CW:0] in_use;
    logic        req_fire;
    logic        rsp_ok;
    logic        push;
    logic        pop;

    always_comb begin
        in_use         = {1'b0, outstanding_q} + {1'b0, count_q};
        imem_req_valid = !reset && (state_q == ST_RUN) && (in_use < DEPTH_C) && !redirect_valid;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
        pop            = (count_q != '0) && out_ready;
        push           = rsp_ok && (drop_cnt_q == '0) && !redirect_valid;

        state_d       = ST_RUN;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_data_d   = fifo_data_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
        fetch_err_d   = fetch_err_q || (imem_rsp_valid && (outstanding_q == '0));

        if (redirect_valid) begin
            // Everything still in flight belongs to the old stream and must be discarded.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            drop_cnt_d = outstanding_q - CW'(rsp_ok);
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_ok && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (push) begin
                fifo_pc_d[tail_q]   = rsp_pc_q;
                fifo_data_d[tail_q] = imem_rsp_data;
                tail_d              = tail_q + 1'b1;
                rsp_pc_d            = rsp_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        out_valid       = (count_q != '0);
        out_pc          = out_valid ? fifo_pc_q[head_q] : 32'h0;
        out_instruction = out_valid ? fifo_data_q[head_q] : NOP;
        fetch_err       = fetch_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Storage needs no reset: reads are masked by count_q.
    always_ff @(posedge clk) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_data_q <= fifo_data_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable latency,
// and a scoreboard of expected PCs checked as the core side consumes words.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_valid_m;
    logic        inj;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instruction;
    logic        fetch_err;

    logic        req_valid_b, rsp_valid_b, out_valid_b, fetch_err_b;
    logic [31:0] addr_b, rsp_data_b, out_pc_b, out_instr_b;

    int n_checks = 0;
    int n_pass   = 0;
    int lat      = 1;
    int cyc      = 0;
    int acc_cnt  = 0;
    bit sb_en    = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t       mq[$];
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    assign imem_rsp_valid = rsp_valid_m | inj;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instruction(out_instruction), .fetch_err(fetch_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid_b), .imem_req_ready(1'b1),
        .imem_req_addr(addr_b), .imem_rsp_valid(rsp_valid_b),
        .imem_rsp_data(rsp_data_b), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .out_valid(out_valid_b), .out_ready(1'b1),
        .out_pc(out_pc_b), .out_instruction(out_instr_b), .fetch_err(fetch_err_b)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Main memory model: in order, always-ready unless imem_req_ready is dropped.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            rsp_valid_m <= 1'b0;
            rsp_data    <= '0;
            acc_cnt     <= 0;
        end else begin
            if (rsp_valid_m) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc + lat});
                acc_cnt <= acc_cnt + 1;
            end
            if (mq.size() != 0 && mq[0].due <= cyc + 1) begin
                rsp_valid_m <= 1'b1;
                rsp_data    <= mem_word(mq[0].addr);
            end else begin
                rsp_valid_m <= 1'b0;
                rsp_data    <= '0;
            end
        end
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (reset) begin
            rsp_valid_b <= 1'b0;
            rsp_data_b  <= '0;
        end else begin
            rsp_valid_b <= req_valid_b;
            rsp_data_b  <= mem_word(addr_b);
        end
    end

    // Scoreboard consumer: compare every word the core takes.
    always @(negedge clk) begin
        if (sb_en && !reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                timeout_fail("sb_underflow");
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_instr", out_instruction, mem_word(e));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        sb_en = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) timeout_fail(tag);
        sb_en = 1'b0;
    endtask

    task automatic wait_acc(input string tag, input int want);
        int n;
        n = 0;
        while (acc_cnt < want && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (acc_cnt < want) timeout_fail(tag);
    endtask

    initial begin
        logic [31:0] got_addr[3];
        logic [31:0] got_pc[3];
        logic [31:0] got_ins[3];
        logic [31:0] exp_w[3];
        int na, no, n;

        reset          = 1'b1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inj            = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instruction, 32'h0000_0013);

        // 1: streaming, latency 1, core always ready
        lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
        sb_en = 1'b1;
        @(negedge clk);
        chk("t1_boot_req_valid", {31'b0, imem_req_valid}, 32'h0);
        @(negedge clk);
        chk("t1_first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("t1_lat_out_valid_lo", {31'b0, out_valid}, 32'h0);
        chk("t1_second_req_addr", imem_req_addr, 32'h4);
        @(negedge clk);
        chk("t1_lat_out_valid_hi", {31'b0, out_valid}, 32'h1);
        wait_drain("t1_drain", 100);
        chk("t1_fetch_err", {31'b0, fetch_err}, 32'h0);

        // 2: core stalled, credit limit of DEPTH requests
        out_ready = 1'b0;
        do_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t2_acc_cnt", 32'(acc_cnt), 32'd2);
        chk("t2_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("t2_head_pc", out_pc, 32'h0);
        chk("t2_head_instr", out_instruction, mem_word(32'h0));
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) sb.push_back(32'(i * 4));
        sb_en     = 1'b1;
        out_ready = 1'b1;
        wait_drain("t2_drain", 100);

        // 3: redirect with two requests in flight
        lat = 3;
        do_reset();
        wait_acc("t3_two_inflight", 2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0101;
        for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(i * 4));
        sb_en = 1'b1;
        @(negedge clk);
        chk("t3_no_req_in_redirect", {31'b0, imem_req_valid}, 32'h0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req_valid) timeout_fail("t3_req_after_redirect");
        else chk("t3_req_addr", imem_req_addr, 32'h100);
        wait_drain("t3_drain", 200);

        // 5: reset with buffered and outstanding words
        lat       = 3;
        out_ready = 1'b0;
        do_reset();
        wait_acc("t5_fill", 2);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) timeout_fail("t5_out_valid_before_reset");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", {31'b0, out_valid}, 32'h0);
        chk("t5_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("t5_fetch_err", {31'b0, fetch_err}, 32'h0);
        repeat (8) @(negedge clk);
        chk("t5_fetch_err_later", {31'b0, fetch_err}, 32'h0);

        // 6: stray response during BOOT
        lat       = 1;
        out_ready = 1'b0;
        do_reset();
        inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        @(negedge clk);
        chk("t6_fetch_err", {31'b0, fetch_err}, 32'h1);
        chk("t6_fifo_empty", {31'b0, out_valid}, 32'h0);
        repeat (6) @(negedge clk);
        chk("t6_fetch_err_sticky", {31'b0, fetch_err}, 32'h1);
        out_ready = 1'b1;

        // 4: address wrap on the second instance
        do_reset();
        na = 0;
        no = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_valid_b && na < 3) begin
                got_addr[na] = addr_b;
                na++;
            end
            if (out_valid_b && no < 3) begin
                got_pc[no]  = out_pc_b;
                got_ins[no] = out_instr_b;
                no++;
            end
        end
        exp_w[0] = 32'hFFFF_FFF8;
        exp_w[1] = 32'hFFFF_FFFC;
        exp_w[2] = 32'h0000_0000;
        if (na < 3 || no < 3) begin
            timeout_fail("t4_wrap_stream");
        end else begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("t4_req_addr%0d", i), got_addr[i], exp_w[i]);
                chk($sformatf("t4_out_pc%0d", i), got_pc[i], exp_w[i]);
                chk($sformatf("t4_out_instr%0d", i), got_ins[i], mem_word(exp_w[i]));
            end
        end
        chk("t4_fetch_err", {31'b0, fetch_err_b}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
